// File: rtl/reg_wb_scheduler_pkg.sv
// rtl/reg_wb_scheduler_pkg.sv - shared types and constants for the register write-back scheduler
package reg_wb_scheduler_pkg;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wb_state_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;

  function automatic logic [NUM_REGS-1:0] idx_mask(input logic [REG_IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction
endpackage

// File: rtl/reg_wb_scheduler_scoreboard.sv
// rtl/reg_wb_scheduler_scoreboard.sv - outstanding-load scoreboard with duplicate-issue flag and source hazard lookup
module reg_scoreboard
  import reg_wb_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] src1_sel,
  input  logic [REG_IDX_W-1:0] src2_sel,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 issue_err,
  output logic                 src_hazard
);
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                dup_issue;

  // A bit being cleared this cycle is free again, so re-issuing it is legal.
  always_comb begin
    set_mask  = set_en ? idx_mask(set_idx) : '0;
    clr_mask  = clr_en ? idx_mask(clr_idx) : '0;
    dup_issue = |(set_mask & pending & ~clr_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      issue_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (dup_issue) issue_err <= 1'b1;
    end
  end

  assign src_hazard = pending[src1_sel] | pending[src2_sel];
endmodule

// File: rtl/reg_wb_scheduler.sv
// rtl/reg_wb_scheduler.sv - arbitrates ALU and load write-backs into setup/strobe/hold pulses for the latch bank
module reg_wb_scheduler
  import reg_wb_scheduler_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_dest,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  input  logic                 ld_issue,
  input  logic [REG_IDX_W-1:0] ld_issue_dest,
  input  logic [REG_IDX_W-1:0] src1_sel,
  input  logic [REG_IDX_W-1:0] src2_sel,
  output logic [REG_IDX_W-1:0] wr_dest,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 wr_en,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 hazard,
  output logic                 busy,
  output logic                 issue_err
);
  localparam int CNT_W = 2;

  wb_state_t        state;
  wb_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  req_id_t          rr_last;
  req_id_t          winner;
  logic             alu_elig;
  logic             ld_elig;
  logic             grant_alu;
  logic             grant_ld;
  logic             alu_take;
  logic             ld_take;
  logic             clr_en;
  logic             sb_hazard;

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (ld_issue),
    .set_idx    (ld_issue_dest),
    .clr_en     (clr_en),
    .clr_idx    (wr_dest),
    .src1_sel   (src1_sel),
    .src2_sel   (src2_sel),
    .pending    (pending),
    .issue_err  (issue_err),
    .src_hazard (sb_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (alu_take || ld_take) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == '0) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU writes to a register with a load in flight wait, so the load cannot overwrite them later.
  always_comb begin
    alu_elig  = alu_valid && !pending[alu_dest];
    ld_elig   = ld_valid;
    grant_alu = alu_elig && (!ld_elig || rr_last == REQ_LD);
    grant_ld  = ld_elig && (!alu_elig || rr_last == REQ_ALU);
    alu_ready = (state == IDLE) && grant_alu;
    ld_ready  = (state == IDLE) && grant_ld;
    wr_en     = (state == STROBE);
    busy      = (state != IDLE);
    clr_en    = (state == HOLD) && (winner == REQ_LD);
    hazard    = sb_hazard | (busy && (wr_dest == src1_sel || wr_dest == src2_sel));
  end

  assign alu_take = alu_valid && alu_ready;
  assign ld_take  = ld_valid && ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rr_last <= REQ_LD;
      winner  <= REQ_ALU;
      wr_dest <= '0;
      wr_data <= '0;
    end else begin
      if (state == SETUP)                  cnt <= CNT_W'(STROBE_CYCLES - 1);
      else if (state == STROBE && cnt != '0) cnt <= cnt - 1'b1;
      if (alu_take) begin
        wr_dest <= alu_dest;
        wr_data <= alu_data;
        winner  <= REQ_ALU;
        rr_last <= REQ_ALU;
      end else if (ld_take) begin
        wr_dest <= ld_dest;
        wr_data <= ld_data;
        winner  <= REQ_LD;
        rr_last <= REQ_LD;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb/tb_reg_wb_scheduler.sv - self-checking bench for reg_wb_scheduler
module tb_reg_wb_scheduler;
  localparam int S  = 1;
  localparam int S4 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid, ld_valid, ld_issue;
  logic [3:0]  alu_dest, ld_dest, ld_issue_dest, src1_sel, src2_sel;
  logic [31:0] alu_data, ld_data;

  logic        alu_ready, ld_ready, wr_en, hazard, busy, issue_err;
  logic [3:0]  wr_dest;
  logic [31:0] wr_data;
  logic [15:0] pending;

  logic        alu_ready_4, ld_ready_4, wr_en_4, hazard_4, busy_4, issue_err_4;
  logic [3:0]  wr_dest_4;
  logic [31:0] wr_data_4;
  logic [15:0] pending_4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_wb_scheduler #(.STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest),
    .src1_sel(src1_sel), .src2_sel(src2_sel),
    .wr_dest(wr_dest), .wr_data(wr_data), .wr_en(wr_en), .pending(pending),
    .hazard(hazard), .busy(busy), .issue_err(issue_err)
  );

  reg_wb_scheduler #(.STROBE_CYCLES(S4)) dut4 (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready_4),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready_4),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest),
    .src1_sel(src1_sel), .src2_sel(src2_sel),
    .wr_dest(wr_dest_4), .wr_data(wr_data_4), .wr_en(wr_en_4), .pending(pending_4),
    .hazard(hazard_4), .busy(busy_4), .issue_err(issue_err_4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    ld_valid = 0; ld_dest = 0; ld_data = 0;
    ld_issue = 0; ld_issue_dest = 0;
    src1_sel = 0; src2_sel = 0;
  endtask

  task automatic apply_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    tick();
    checks++;
    if ({wr_en, busy, issue_err, pending, wr_dest, wr_data} !== 55'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {wr_en, busy, issue_err, pending, wr_dest, wr_data});
    end
    rst = 0;
    alu_valid = 1; alu_dest = 1; ld_valid = 1; ld_dest = 2;
    #1;
    checks++;
    if ({alu_ready, ld_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_tie got=%b exp=10", {alu_ready, ld_ready});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_single_alu();
    apply_reset();
    alu_valid = 1; alu_dest = 4'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      failures++; $display("FAIL single_ready got=%b exp=1", alu_ready);
    end
    tick();
    alu_valid = 0;
    @(negedge clk);
    checks++;
    if ({busy, wr_en, wr_dest, wr_data} !== {1'b1, 1'b0, 4'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL single_setup got=%h exp=%h", {busy, wr_en, wr_dest, wr_data}, {1'b1, 1'b0, 4'd5, 32'hDEADBEEF});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({busy, wr_en} !== 2'b11) begin
      failures++; $display("FAIL single_strobe got=%b exp=11", {busy, wr_en});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({busy, wr_en, wr_data} !== {2'b10, 32'hDEADBEEF}) begin
      failures++; $display("FAIL single_hold got=%h exp=%h", {busy, wr_en, wr_data}, {2'b10, 32'hDEADBEEF});
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL single_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_tie();
    bit ld_turn;
    apply_reset();
    alu_valid = 1; alu_dest = 4'd3; alu_data = 32'hA0A0_0003;
    ld_valid = 1; ld_dest = 4'd7; ld_data = 32'hB0B0_0007;
    for (int k = 0; k < 16; k++) begin
      ld_turn = ((k / 4) % 2) == 1;
      @(negedge clk);
      if (k % 4 == 0) begin
        checks++;
        if ({alu_ready, ld_ready} !== {!ld_turn, ld_turn}) begin
          failures++;
          $display("FAIL tie_grant k=%0d got=%b exp=%b", k, {alu_ready, ld_ready}, {!ld_turn, ld_turn});
        end
      end else if (k % 4 == 1) begin
        checks++;
        if ({wr_dest, wr_data} !== (ld_turn ? {4'd7, 32'hB0B0_0007} : {4'd3, 32'hA0A0_0003})) begin
          failures++; $display("FAIL tie_capture k=%0d got=%h", k, {wr_dest, wr_data});
        end
      end else begin
        checks++;
        if ({alu_ready, ld_ready} !== 2'b00) begin
          failures++; $display("FAIL tie_busy_ready k=%0d got=%b exp=00", k, {alu_ready, ld_ready});
        end
      end
      tick();
    end
    clear_inputs();
    repeat (4) tick();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    ld_issue = 1; ld_issue_dest = 4'd9;
    tick();
    ld_issue = 0;
    src1_sel = 4'd9;
    alu_valid = 1; alu_dest = 4'd9; alu_data = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({pending, hazard, alu_ready} !== {16'h0200, 1'b1, 1'b0}) begin
      failures++; $display("FAIL sb_issue got=%h exp=%h", {pending, hazard, alu_ready}, {16'h0200, 2'b10});
    end
    tick();
    ld_valid = 1; ld_dest = 4'd9; ld_data = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if ({alu_ready, ld_ready} !== 2'b01) begin
      failures++; $display("FAIL sb_ld_grant got=%b exp=01", {alu_ready, ld_ready});
    end
    tick();
    ld_valid = 0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({pending, alu_ready, wr_data} !== {16'h0200, 1'b0, 32'h0BAD_F00D}) begin
      failures++; $display("FAIL sb_hold got=%h", {pending, alu_ready, wr_data});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({pending, alu_ready} !== {16'h0000, 1'b1}) begin
      failures++; $display("FAIL sb_cleared got=%h exp=00001", {pending, alu_ready});
    end
    tick();
    alu_valid = 0; src1_sel = 0;
    @(negedge clk);
    checks++;
    if ({wr_dest, wr_data} !== {4'd9, 32'h1234_5678}) begin
      failures++; $display("FAIL sb_alu_write got=%h exp=%h", {wr_dest, wr_data}, {4'd9, 32'h1234_5678});
    end
    repeat (3) tick();
  endtask

  task automatic test_double_issue();
    apply_reset();
    ld_issue = 1; ld_issue_dest = 4'd2;
    tick();
    @(negedge clk);
    checks++;
    if (issue_err !== 1'b0) begin
      failures++; $display("FAIL dbl_first got=%b exp=0", issue_err);
    end
    tick();
    ld_issue = 0;
    @(negedge clk);
    checks++;
    if (issue_err !== 1'b1) begin
      failures++; $display("FAIL dbl_second got=%b exp=1", issue_err);
    end
    ld_valid = 1; ld_dest = 4'd2; ld_data = 32'h2222_2222;
    tick();
    ld_valid = 0;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if ({pending, issue_err} !== {16'h0000, 1'b1}) begin
      failures++; $display("FAIL dbl_sticky got=%h exp=00001", {pending, issue_err});
    end
    rst = 1;
    #1;
    checks++;
    if (issue_err !== 1'b0) begin
      failures++; $display("FAIL dbl_reset got=%b exp=0", issue_err);
    end
    apply_reset();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    ld_issue = 1; ld_issue_dest = 4'd4;
    tick();
    ld_issue = 0;
    ld_valid = 1; ld_dest = 4'd4; ld_data = 32'h4444_4444;
    tick();
    ld_valid = 0;
    tick();
    tick();
    ld_issue = 1; ld_issue_dest = 4'd4;
    @(negedge clk);
    checks++;
    if ({busy, wr_en} !== 2'b10) begin
      failures++; $display("FAIL same_in_hold got=%b exp=10", {busy, wr_en});
    end
    tick();
    ld_issue = 0;
    @(negedge clk);
    checks++;
    if ({pending, issue_err} !== {16'h0010, 1'b0}) begin
      failures++; $display("FAIL same_set_wins got=%h exp=%h", {pending, issue_err}, {16'h0010, 1'b0});
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    ld_issue = 1; ld_issue_dest = 4'd1;
    alu_valid = 1; alu_dest = 4'd6; alu_data = 32'h6666_6666;
    @(negedge clk);
    checks++;
    if (alu_ready_4 !== 1'b1) begin
      failures++; $display("FAIL mid_accept got=%b exp=1", alu_ready_4);
    end
    tick();
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({wr_en_4, pending_4} !== {1'b1, 16'h0002}) begin
      failures++; $display("FAIL mid_strobe2 got=%h exp=%h", {wr_en_4, pending_4}, {1'b1, 16'h0002});
    end
    rst = 1;
    #1;
    checks++;
    if ({wr_en_4, busy_4, pending_4} !== 18'd0) begin
      failures++; $display("FAIL mid_reset got=%h exp=0", {wr_en_4, busy_4, pending_4});
    end
    @(negedge clk);
    rst = 0;
    alu_valid = 1; alu_dest = 4'd6;
    #1;
    checks++;
    if (alu_ready_4 !== 1'b1) begin
      failures++; $display("FAIL mid_after_reset got=%b exp=1", alu_ready_4);
    end
    clear_inputs();
    apply_reset();
  endtask

  // Reference timing: a write accepted in cycle t strobes in cycles t+2..t+1+S,
  // holds in t+2+S, and the next acceptance is possible from t+3+S.
  task automatic test_random_traffic();
    int          acc, free_at;
    bit          have_acc, win_ld, rr_ld, err_m, e_ar, e_lr, e_we, e_busy, e_hz, a_el;
    logic [15:0] pm;
    logic [3:0]  wd;
    logic [31:0] wdat;
    logic [57:0] exp_v, got_v;
    apply_reset();
    acc = 0; free_at = 0; have_acc = 0; win_ld = 0; rr_ld = 1; err_m = 0;
    pm = 0; wd = 0; wdat = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_dest = 4'($urandom_range(0, 15));
      alu_data = $urandom;
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_dest = 4'($urandom_range(0, 15));
      ld_data = $urandom;
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_issue_dest = 4'($urandom_range(0, 15));
      src1_sel = 4'($urandom_range(0, 15));
      src2_sel = 4'($urandom_range(0, 15));
      @(negedge clk);
      e_busy = (cyc < free_at);
      a_el = alu_valid && !pm[alu_dest];
      e_ar = !e_busy && a_el && (!ld_valid || rr_ld);
      e_lr = !e_busy && ld_valid && (!a_el || !rr_ld);
      e_we = have_acc && (cyc >= acc + 2) && (cyc <= acc + 1 + S);
      e_hz = pm[src1_sel] | pm[src2_sel] | (e_busy && (wd == src1_sel || wd == src2_sel));
      exp_v = {e_ar, e_lr, e_we, e_busy, e_hz, err_m, pm, wd, wdat};
      got_v = {alu_ready, ld_ready, wr_en, busy, hazard, issue_err, pending, wr_dest, wr_data};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_v, exp_v);
      end
      if (have_acc && win_ld && cyc == acc + 2 + S) pm[wd] = 1'b0;
      if (ld_issue) begin
        if (pm[ld_issue_dest]) err_m = 1'b1;
        pm[ld_issue_dest] = 1'b1;
      end
      if (e_ar || e_lr) begin
        have_acc = 1; acc = cyc; free_at = cyc + S + 3;
        win_ld = e_lr; rr_ld = e_lr;
        wd = e_lr ? ld_dest : alu_dest;
        wdat = e_lr ? ld_data : alu_data;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_alu();
    test_tie();
    test_scoreboard();
    test_double_issue();
    test_same_cycle();
    test_reset_mid_write();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
